phys_reg_free_list: RTL

// Circular free list of physical registers feeding the dual-issue rename stage.
// - Hands out up to 2 free physical tags per cycle: the dest_phys / dest_phys2 of the rename stage.
// - Takes back up to 2 tags per cycle from retire: the overwritten dest tags, via free_regs[0:1].
// - Keeps an in-use bitmap and flags illegal frees.

---
 rtl/phys_reg_free_list_if.sv | 36 +++
 rtl/phys_reg_free_list.sv | 100 ++++++++++
 2 files changed

// File: rtl/phys_reg_free_list_if.sv
`default_nettype none
// ============================================================================
// Module      : phys_reg_free_list_if
// Description : Rename-side allocate and retire-side free ports of the
//               physical register free list.
// Revision    : 1.0 - initial release
// ============================================================================
interface phys_reg_free_list_if #(
    parameter int NUM_PHYS = 64,
    parameter int PREG_W   = $clog2(NUM_PHYS)
);
    logic [1:0]          alloc_req;
    logic                alloc_grant;
    logic [PREG_W-1:0]   alloc_preg0;
    logic [PREG_W-1:0]   alloc_preg1;
    logic [1:0]          free_valid;
    logic [PREG_W-1:0]   free_preg0;
    logic [PREG_W-1:0]   free_preg1;
    logic [PREG_W:0]     free_count;
    logic [NUM_PHYS-1:0] in_use;
    logic                err_double_free;

    // master = rename/retire pipeline, slave = the free list itself
    modport master (
        output alloc_req, free_valid, free_preg0, free_preg1,
        input  alloc_grant, alloc_preg0, alloc_preg1, free_count, in_use,
               err_double_free
    );

    modport slave (
        input  alloc_req, free_valid, free_preg0, free_preg1,
        output alloc_grant, alloc_preg0, alloc_preg1, free_count, in_use,
               err_double_free
    );
endinterface
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : phys_reg_free_list
// Description : Circular free list of physical tags; two allocations and two
//               retire frees per cycle, with in-use bitmap and free checking.
// Revision    : 1.0 - initial release
// ============================================================================
module phys_reg_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int PREG_W   = $clog2(NUM_PHYS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    phys_reg_free_list_if.slave   fl
);
    localparam int c_NUM_FREE = NUM_PHYS - NUM_ARCH;

    logic [PREG_W-1:0]   r_list [NUM_PHYS];
    logic [PREG_W-1:0]   r_head;
    logic [PREG_W-1:0]   r_tail;
    logic [PREG_W:0]     r_count;
    logic [NUM_PHYS-1:0] r_in_use;
    logic                r_err;

    logic [1:0]          w_n_req;
    logic [1:0]          w_n_acc;
    logic                w_grant;
    logic                w_same;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_bad;
    logic [PREG_W-1:0]   w_head_p1;
    logic [PREG_W-1:0]   w_tail_p1;
    logic [PREG_W-1:0]   w_wr_addr1;
    logic [PREG_W-1:0]   w_preg1;
    logic [NUM_PHYS-1:0] w_in_use_next;
    logic [PREG_W:0]     w_count_next;

    // Allocation: grant is all-or-nothing so rename stalls both slots together
    assign w_n_req   = {1'b0, fl.alloc_req[0]} + {1'b0, fl.alloc_req[1]};
    assign w_grant   = ((PREG_W+1)'(w_n_req) <= r_count);
    assign w_head_p1 = r_head + PREG_W'(1);
    assign w_preg1   = fl.alloc_req[0] ? r_list[w_head_p1] : r_list[r_head];

    assign fl.alloc_grant = w_grant;
    assign fl.alloc_preg0 = r_list[r_head];
    assign fl.alloc_preg1 = w_preg1;

    // Free filtering: x0 is silently ignored; duplicate tags in one cycle push once
    assign w_same = (fl.free_valid == 2'b11) && (fl.free_preg0 == fl.free_preg1);
    assign w_acc0 = fl.free_valid[0] && (fl.free_preg0 != '0) && r_in_use[fl.free_preg0];
    assign w_acc1 = fl.free_valid[1] && (fl.free_preg1 != '0) && r_in_use[fl.free_preg1]
                    && !w_same;
    assign w_bad  = (fl.free_valid[0] && (fl.free_preg0 != '0) && !r_in_use[fl.free_preg0])
                 || (fl.free_valid[1] && (fl.free_preg1 != '0) && !r_in_use[fl.free_preg1])
                 || (w_same && (fl.free_preg0 != '0));

    assign w_n_acc    = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_tail_p1  = r_tail + PREG_W'(1);
    assign w_wr_addr1 = w_acc0 ? w_tail_p1 : r_tail;

    assign w_count_next = r_count + (PREG_W+1)'(w_n_acc)
                        - (w_grant ? (PREG_W+1)'(w_n_req) : '0);

    always_comb begin
        w_in_use_next = r_in_use;
        if (w_acc0) w_in_use_next[fl.free_preg0] = 1'b0;
        if (w_acc1) w_in_use_next[fl.free_preg1] = 1'b0;
        if (w_grant && fl.alloc_req[0]) w_in_use_next[r_list[r_head]] = 1'b1;
        if (w_grant && fl.alloc_req[1]) w_in_use_next[w_preg1]        = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Entries beyond the free region are don't-care; fill uniformly
            for (int i = 0; i < NUM_PHYS; i++) begin
                r_list[i] <= PREG_W'(NUM_ARCH + i);
            end
            r_head   <= '0;
            r_tail   <= PREG_W'(c_NUM_FREE);
            r_count  <= (PREG_W+1)'(c_NUM_FREE);
            r_in_use <= {{c_NUM_FREE{1'b0}}, {NUM_ARCH{1'b1}}};
            r_err    <= 1'b0;
        end else begin
            if (w_acc0) r_list[r_tail]     <= fl.free_preg0;
            if (w_acc1) r_list[w_wr_addr1] <= fl.free_preg1;
            r_head   <= r_head + (w_grant ? PREG_W'(w_n_req) : '0);
            r_tail   <= r_tail + PREG_W'(w_n_acc);
            r_count  <= w_count_next;
            r_in_use <= w_in_use_next;
            r_err    <= r_err | w_bad;
        end
    end

    assign fl.free_count      = r_count;
    assign fl.in_use          = r_in_use;
    assign fl.err_double_free = r_err;
endmodule
`default_nettype wire
